// File: rtl/boton_multicanal.sv
// -----------------------------------------------------------------------------
// boton_multicanal
//   N-channel push-button conditioner. Each channel has its own 2-FF
//   synchroniser, polarity normalisation, a five-state debounce FSM and one
//   shared-purpose counter. Per channel it reports the debounced pressed level
//   plus one-cycle press, release and long-press pulses.
//
//   Optional feature macro: BOTON_AUTOREPEAT_EN
//     defined   -> after a long press, btn_repeat pulses every REPEAT_CYC cycles
//                  while the button stays held.
//     undefined -> btn_repeat is tied to 0 and the repeat logic is not built.
// -----------------------------------------------------------------------------
module boton_multicanal #(
    parameter int N_CH         = 4,
    parameter int DEBOUNCE_CYC = 5000,
    parameter int LONG_CYC     = 25000000,
    parameter int REPEAT_CYC   = 5000000,
    parameter bit ACTIVE_LOW   = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N_CH-1:0] btn_in,
    output logic [N_CH-1:0] btn_level,
    output logic [N_CH-1:0] btn_press,
    output logic [N_CH-1:0] btn_release,
    output logic [N_CH-1:0] btn_long,
    output logic [N_CH-1:0] btn_repeat
);

    // -------------------------------------------------------------------------
    // Counter sizing: one counter per channel is reused for press debounce,
    // long-press timing, release debounce and (optionally) repeat timing, so it
    // must hold the largest terminal count.
    // -------------------------------------------------------------------------
    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    localparam int CNT_MAX = max3(DEBOUNCE_CYC, LONG_CYC, REPEAT_CYC);
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYC - 1);
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYC - 1);
`ifdef BOTON_AUTOREPEAT_EN
    localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYC - 1);
`endif

    // Level the synchroniser holds while the button is not pressed.
    localparam logic SYNC_IDLE = ACTIVE_LOW;

    typedef enum logic [2:0] {
        S_IDLE,      // released, waiting for an active sample
        S_DB_PRESS,  // press candidate, counting stable active samples
        S_HELD,      // pressed, counting towards the long-press threshold
        S_LONG,      // long press reached (repeat timing lives here)
        S_DB_REL     // release candidate, level still reported as pressed
    } state_t;

    for (genvar ch = 0; ch < N_CH; ch++) begin : g_ch

        logic             sync_meta;
        logic             sync_q;
        logic             s;
        state_t           state;
        logic [CNT_W-1:0] cnt;
        logic             long_flag;
        logic             level_q;
        logic             press_q;
        logic             release_q;
        logic             long_q;
`ifdef BOTON_AUTOREPEAT_EN
        logic             repeat_q;
`endif

        // Two-flop synchroniser for the asynchronous pin.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                // NOTE: the synchroniser resets to the released pin level, not
                // to 0; with active-low pins a 0 here would look like a press
                // the moment reset lifts.
                sync_meta <= SYNC_IDLE;
                sync_q    <= SYNC_IDLE;
            end else begin
                // NOTE: non-blocking assignments let sync_q take the old
                // sync_meta, giving two real flop stages; blocking here would
                // collapse the chain into a single flop.
                sync_meta <= btn_in[ch];
                sync_q    <= sync_meta;
            end
        end

        // After normalisation, s = 1 always means "pressed".
        assign s = ACTIVE_LOW ? ~sync_q : sync_q;

        // Debounce / hold FSM with registered level and single-cycle pulses.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                state     <= S_IDLE;
                cnt       <= '0;
                long_flag <= 1'b0;
                level_q   <= 1'b0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
                long_q    <= 1'b0;
`ifdef BOTON_AUTOREPEAT_EN
                repeat_q  <= 1'b0;
`endif
            end else begin
                // Pulses default low so each one lasts exactly one cycle.
                press_q   <= 1'b0;
                release_q <= 1'b0;
                long_q    <= 1'b0;
`ifdef BOTON_AUTOREPEAT_EN
                repeat_q  <= 1'b0;
`endif
                case (state)
                    S_IDLE: begin
                        if (s) begin
                            state <= S_DB_PRESS;
                            cnt   <= '0;
                        end
                    end

                    S_DB_PRESS: begin
                        if (!s) begin
                            // Bounce before acceptance: silently forget it.
                            state <= S_IDLE;
                            cnt   <= '0;
                        end else if (cnt == DB_LAST) begin
                            state   <= S_HELD;
                            cnt     <= '0;
                            level_q <= 1'b1;
                            press_q <= 1'b1;
                        end else begin
                            cnt <= cnt + CNT_ONE;
                        end
                    end

                    S_HELD: begin
                        if (!s) begin
                            state     <= S_DB_REL;
                            cnt       <= '0;
                            long_flag <= 1'b0;
                        end else if (cnt == LONG_LAST) begin
                            state  <= S_LONG;
                            cnt    <= '0;
                            long_q <= 1'b1;
                        end else begin
                            cnt <= cnt + CNT_ONE;
                        end
                    end

                    S_LONG: begin
                        if (!s) begin
                            // Remember the long press so a release bounce
                            // returns here instead of re-arming btn_long.
                            state     <= S_DB_REL;
                            cnt       <= '0;
                            long_flag <= 1'b1;
                        end else begin
`ifdef BOTON_AUTOREPEAT_EN
                            if (cnt == REP_LAST) begin
                                cnt      <= '0;
                                repeat_q <= 1'b1;
                            end else begin
                                cnt <= cnt + CNT_ONE;
                            end
`else
                            cnt <= '0;
`endif
                        end
                    end

                    S_DB_REL: begin
                        if (s) begin
                            // Release bounce: resume the hold without a new
                            // press pulse; the timing phase restarts.
                            state <= long_flag ? S_LONG : S_HELD;
                            cnt   <= '0;
                        end else if (cnt == DB_LAST) begin
                            state     <= S_IDLE;
                            cnt       <= '0;
                            level_q   <= 1'b0;
                            release_q <= 1'b1;
                        end else begin
                            cnt <= cnt + CNT_ONE;
                        end
                    end

                    default: begin
                        state   <= S_IDLE;
                        cnt     <= '0;
                        level_q <= 1'b0;
                    end
                endcase
            end
        end

        assign btn_level[ch]   = level_q;
        assign btn_press[ch]   = press_q;
        assign btn_release[ch] = release_q;
        assign btn_long[ch]    = long_q;
`ifdef BOTON_AUTOREPEAT_EN
        assign btn_repeat[ch]  = repeat_q;
`endif
    end

`ifndef BOTON_AUTOREPEAT_EN
    assign btn_repeat = '0;
`endif

endmodule
